// File: rtl/demux_pkg.sv
// Shared constants and slot state encoding for the 1-to-4 stream demultiplexer.
// The optional per-channel transfer counters are enabled with DEMUX_CNT_EN.
package demux_pkg;

    localparam int NUM_OUT = 4;
    localparam int SEL_W   = 2;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

    // One-hot decode of a channel select; bit i set when sel == i.
    function automatic logic [NUM_OUT-1:0] sel_to_onehot(input logic [SEL_W-1:0] sel);
        logic [NUM_OUT-1:0] onehot;
        onehot = '0;
        onehot[sel] = 1'b1;
        return onehot;
    endfunction

endpackage

// File: rtl/demux_out_slot.sv
// One-entry valid/ready holding slot for one demux output channel.
// With DEMUX_CNT_EN defined it also keeps a saturating count of completed drains.
module demux_out_slot
    import demux_pkg::*;
#(
    parameter int DATA_W = 8
`ifdef DEMUX_CNT_EN
    , parameter int CNT_W = 16
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic [DATA_W-1:0] load_data_i,
    input  logic              drain_ready_i,
    output logic              slot_ready_o,
    output logic              out_valid_o,
    output logic [DATA_W-1:0] out_data_o
`ifdef DEMUX_CNT_EN
    , output logic [CNT_W-1:0] out_cnt_o
`endif
);

    slot_state_e       state_q, state_d;
    logic [DATA_W-1:0] data_q, data_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SLOT_EMPTY;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
        end
    end

    // A simultaneous drain and load keeps the slot FULL with the new word.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        case (state_q)
            SLOT_EMPTY: begin
                if (load_i) begin
                    state_d = SLOT_FULL;
                end
            end
            SLOT_FULL: begin
                if (drain_ready_i && !load_i) begin
                    state_d = SLOT_EMPTY;
                end
            end
            default: state_d = SLOT_EMPTY;
        endcase
        if (load_i) begin
            data_d = load_data_i;
        end
    end

    always_comb begin
        out_valid_o  = (state_q == SLOT_FULL);
        out_data_o   = data_q;
        slot_ready_o = (state_q == SLOT_EMPTY) || drain_ready_i;
    end

`ifdef DEMUX_CNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic             drain;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign drain = (state_q == SLOT_FULL) && drain_ready_i;

    always_comb begin
        cnt_d = cnt_q;
        if (drain && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign out_cnt_o = cnt_q;
`endif

endmodule

// File: rtl/demux1to4_stream.sv
// Registered 1-to-4 stream demultiplexer: routes each accepted word to the slot chosen by in_sel.
// Defining DEMUX_CNT_EN adds out_cnt with per-channel saturating transfer counters.
module demux1to4_stream
    import demux_pkg::*;
#(
    parameter int DATA_W = 8
`ifdef DEMUX_CNT_EN
    , parameter int CNT_W = 16
`endif
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    input  logic [DATA_W-1:0]           in_data,
    input  logic [SEL_W-1:0]            in_sel,
    output logic                        in_ready,
    output logic [NUM_OUT-1:0]          out_valid,
    output logic [NUM_OUT*DATA_W-1:0]   out_data,
    input  logic [NUM_OUT-1:0]          out_ready
`ifdef DEMUX_CNT_EN
    , output logic [NUM_OUT*CNT_W-1:0]  out_cnt
`endif
);

    logic [NUM_OUT-1:0] sel_onehot;
    logic [NUM_OUT-1:0] slot_ready;
    logic [NUM_OUT-1:0] slot_load;
    logic               accept;

    // Readiness depends only on the selected slot, so a stalled lane never blocks the others.
    always_comb begin
        sel_onehot = sel_to_onehot(in_sel);
        in_ready   = slot_ready[in_sel];
        accept     = in_valid && in_ready;
    end

    generate
        for (genvar gi = 0; gi < NUM_OUT; gi++) begin : g_slot
            assign slot_load[gi] = accept && sel_onehot[gi];

            demux_out_slot #(
                .DATA_W (DATA_W)
`ifdef DEMUX_CNT_EN
                , .CNT_W (CNT_W)
`endif
            ) u_slot (
                .clk           (clk),
                .rst           (rst),
                .load_i        (slot_load[gi]),
                .load_data_i   (in_data),
                .drain_ready_i (out_ready[gi]),
                .slot_ready_o  (slot_ready[gi]),
                .out_valid_o   (out_valid[gi]),
                .out_data_o    (out_data[gi*DATA_W +: DATA_W])
`ifdef DEMUX_CNT_EN
                , .out_cnt_o   (out_cnt[gi*CNT_W +: CNT_W])
`endif
            );
        end
    endgenerate

endmodule

// File: tb/tb_demux1to4_stream.sv
// Directed self-checking bench for demux1to4_stream; counter checks run when DEMUX_CNT_EN is defined.
module tb_demux1to4_stream;

    localparam int DATA_W = 8;
`ifdef DEMUX_CNT_EN
    localparam int CNT_W  = 2;
`endif

    logic                clk;
    logic                rst;
    logic                in_valid;
    logic [DATA_W-1:0]   in_data;
    logic [1:0]          in_sel;
    logic                in_ready;
    logic [3:0]          out_valid;
    logic [4*DATA_W-1:0] out_data;
    logic [3:0]          out_ready;
`ifdef DEMUX_CNT_EN
    logic [4*CNT_W-1:0]  out_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    demux1to4_stream #(
        .DATA_W (DATA_W)
`ifdef DEMUX_CNT_EN
        , .CNT_W (CNT_W)
`endif
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready)
`ifdef DEMUX_CNT_EN
        , .out_cnt (out_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, obs);
        end
    endtask

    // Advance one edge; outputs are sampled 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DATA_W-1:0] slot_data(input int i);
        return out_data[i*DATA_W +: DATA_W];
    endfunction

    task automatic drive(input logic v, input logic [DATA_W-1:0] d, input logic [1:0] s);
        in_valid = v;
        in_data  = d;
        in_sel   = s;
        #1;
    endtask

    logic [DATA_W-1:0] t2_data  [4] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    logic [3:0]        t2_valid [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_sel = '0; out_ready = 4'b0000;
        #2;

        // 1: reset with in_valid held high
        drive(1'b1, 8'hEE, 2'd0);
        tick();
        tick();
        check_eq("rst_valid", 64'(out_valid), 64'h0);
        check_eq("rst_data", 64'(out_data), 64'h0);
`ifdef DEMUX_CNT_EN
        check_eq("rst_cnt", 64'(out_cnt), 64'h0);
`endif
        rst = 1'b0;
        drive(1'b0, 8'h00, 2'd0);
        check_eq("rst_in_ready", 64'(in_ready), 64'h1);

        // 2: back-to-back words to all four channels, consumers always ready
        out_ready = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, t2_data[i], 2'(i));
            check_eq($sformatf("t2_in_ready%0d", i), 64'(in_ready), 64'h1);
            tick();
            check_eq($sformatf("t2_valid%0d", i), 64'(out_valid), 64'(t2_valid[i]));
            check_eq($sformatf("t2_data%0d", i), 64'(slot_data(i)), 64'(t2_data[i]));
        end
        drive(1'b0, 8'h00, 2'd0);
        tick();
        check_eq("t2_idle", 64'(out_valid), 64'h0);

        // 3: stalled channel 2 blocks only words for channel 2
        out_ready = 4'b1011;
        drive(1'b1, 8'h55, 2'd2);
        tick();
        check_eq("t3_valid_55", 64'(out_valid), 64'b0100);
        check_eq("t3_data_55", 64'(slot_data(2)), 64'h55);
        drive(1'b1, 8'h66, 2'd2);
        check_eq("t3_in_ready_stall", 64'(in_ready), 64'h0);
        tick();
        check_eq("t3_hold_data", 64'(slot_data(2)), 64'h55);
        check_eq("t3_hold_valid", 64'(out_valid), 64'b0100);
        out_ready = 4'b1111;
        #1;
        check_eq("t3_in_ready_go", 64'(in_ready), 64'h1);
        tick();
        check_eq("t3_reload_valid", 64'(out_valid), 64'b0100);
        check_eq("t3_reload_data", 64'(slot_data(2)), 64'h66);
        drive(1'b1, 8'h77, 2'd1);
        tick();
        check_eq("t3_ch1_valid", 64'(out_valid), 64'b0010);
        check_eq("t3_ch1_data", 64'(slot_data(1)), 64'h77);
        drive(1'b0, 8'h00, 2'd0);
        tick();

        // 4: drain and reload slot 3 in the same cycle
        out_ready = 4'b0000;
        drive(1'b1, 8'h88, 2'd3);
        tick();
        check_eq("t4_full", 64'(out_valid), 64'b1000);
        out_ready = 4'b1111;
        drive(1'b1, 8'h99, 2'd3);
        check_eq("t4_in_ready", 64'(in_ready), 64'h1);
        tick();
        check_eq("t4_valid", 64'(out_valid), 64'b1000);
        check_eq("t4_data", 64'(slot_data(3)), 64'h99);
        drive(1'b0, 8'h00, 2'd0);
        tick();
        check_eq("t4_empty", 64'(out_valid), 64'h0);

        // 5: reset mid-stream discards held words
        out_ready = 4'b0000;
        drive(1'b1, 8'h11, 2'd0);
        tick();
        drive(1'b1, 8'h22, 2'd1);
        tick();
        check_eq("t5_loaded", 64'(out_valid), 64'b0011);
        rst = 1'b1;
        drive(1'b1, 8'h33, 2'd2);
        tick();
        check_eq("t5_rst_valid", 64'(out_valid), 64'h0);
        check_eq("t5_rst_data", 64'(out_data), 64'h0);
        rst = 1'b0;
        drive(1'b0, 8'h00, 2'd0);
        tick();
        check_eq("t5_after_valid", 64'(out_valid), 64'h0);

`ifdef DEMUX_CNT_EN
        // 6: five drains on channel 0 saturate a 2-bit counter at 3
        out_ready = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 8'(8'h40 + k), 2'd0);
            tick();
            check_eq($sformatf("t6_data%0d", k), 64'(slot_data(0)), 64'(8'h40 + k));
            if (k >= 1) begin
                check_eq($sformatf("t6_cnt%0d", k), 64'(out_cnt[1:0]), 64'((k > 3) ? 3 : k));
            end
        end
        drive(1'b0, 8'h00, 2'd0);
        tick();
        check_eq("t6_cnt_final", 64'(out_cnt[1:0]), 64'h3);
        check_eq("t6_cnt_others", 64'(out_cnt[7:2]), 64'h0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
